// File: rtl/hxd_arb_pkg.sv
// Shared types for the data-RAM arbiter: owners, arbiter states, RAM command payload.
package hxd_arb_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } ram_cmd_t;

endpackage

// File: rtl/arb_wait_cnt.sv
// Saturating HOST starvation counter.
//   clk, rst   : clock, synchronous active-high reset
//   inc        : HOST waiting this cycle (count up, saturating at MAX_WAIT-1)
//   clr        : HOST granted or idle (clear, dominates inc)
//   at_limit   : counter has reached MAX_WAIT-1
module arb_wait_cnt #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single data-RAM port between the CPU and the SPI host loader.
// Fixed CPU priority with a starvation override for HOST, a HOST lock mode that
// stalls the CPU during bulk transfers, and 1-cycle read-data return routing.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   cpu_*  (req/we/addr/wdata/be in, gnt/rvld/rdata out) : CPU port
//   host_* (req/lock/we/addr/wdata/be in, gnt/rvld/rdata out) : HOST port
//   ram_*  (en/we/addr/wdata/be out, rdata in) : RAM port
module dram_arbiter
  import hxd_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cpu_req_i,
  input  logic            cpu_we_i,
  input  logic [XLEN-1:0] cpu_addr_i,
  input  logic [XLEN-1:0] cpu_wdata_i,
  input  logic [BE_W-1:0] cpu_be_i,
  output logic            cpu_gnt_o,
  output logic            cpu_rvld_o,
  output logic [XLEN-1:0] cpu_rdata_o,
  input  logic            host_req_i,
  input  logic            host_lock_i,
  input  logic            host_we_i,
  input  logic [XLEN-1:0] host_addr_i,
  input  logic [XLEN-1:0] host_wdata_i,
  input  logic [BE_W-1:0] host_be_i,
  output logic            host_gnt_o,
  output logic            host_rvld_o,
  output logic [XLEN-1:0] host_rdata_o,
  output logic            ram_en_o,
  output logic            ram_we_o,
  output logic [XLEN-1:0] ram_addr_o,
  output logic [XLEN-1:0] ram_wdata_o,
  output logic [BE_W-1:0] ram_be_o,
  input  logic [XLEN-1:0] ram_rdata_i
);

  arb_state_t      state_q, state_d;
  owner_t          rd_owner_q, rd_owner_d;
  logic            cpu_win, host_win, at_limit;
  logic [XLEN-1:0] cpu_rdata_q, host_rdata_q;
  ram_cmd_t        cmd;

  arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk      (clk_i),
    .rst      (rst_i),
    .inc      (host_req_i && !host_win),
    .clr      (host_win || !host_req_i),
    .at_limit (at_limit)
  );

  // Grant decision and next state; everything held off while in reset.
  always_comb begin
    cpu_win  = 1'b0;
    host_win = 1'b0;
    state_d  = state_q;
    if (!rst_i) begin
      case (state_q)
        ARB: begin
          if (host_req_i && (!cpu_req_i || at_limit)) begin
            host_win = 1'b1;
          end else if (cpu_req_i) begin
            cpu_win = 1'b1;
          end
          if (host_win && host_lock_i) state_d = LOCK;
        end
        LOCK: begin
          host_win = host_req_i;
          if (!host_lock_i) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  // Command mux from the winner; byte enables are zeroed on reads.
  always_comb begin
    cmd        = '0;
    rd_owner_d = OWN_NONE;
    if (host_win) begin
      cmd.we     = host_we_i;
      cmd.addr   = host_addr_i;
      cmd.wdata  = host_wdata_i;
      cmd.be     = host_be_i & {BE_W{host_we_i}};
      if (!host_we_i) rd_owner_d = OWN_HOST;
    end else if (cpu_win) begin
      cmd.we     = cpu_we_i;
      cmd.addr   = cpu_addr_i;
      cmd.wdata  = cpu_wdata_i;
      cmd.be     = cpu_be_i & {BE_W{cpu_we_i}};
      if (!cpu_we_i) rd_owner_d = OWN_CPU;
    end
  end

  // State, read owner and per-owner held read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ARB;
      rd_owner_q   <= OWN_NONE;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      if (rd_owner_q == OWN_CPU)  cpu_rdata_q  <= ram_rdata_i;
      if (rd_owner_q == OWN_HOST) host_rdata_q <= ram_rdata_i;
    end
  end

  assign cpu_gnt_o   = cpu_win;
  assign host_gnt_o  = host_win;
  assign ram_en_o    = cpu_win || host_win;
  assign ram_we_o    = cmd.we;
  assign ram_addr_o  = cmd.addr;
  assign ram_wdata_o = cmd.wdata;
  assign ram_be_o    = cmd.be;

  // Read return passes RAM data straight through to the owner in its valid cycle.
  assign cpu_rvld_o   = !rst_i && (rd_owner_q == OWN_CPU);
  assign host_rvld_o  = !rst_i && (rd_owner_q == OWN_HOST);
  assign cpu_rdata_o  = rst_i ? '0 : (rd_owner_q == OWN_CPU)  ? ram_rdata_i : cpu_rdata_q;
  assign host_rdata_o = rst_i ? '0 : (rd_owner_q == OWN_HOST) ? ram_rdata_i : host_rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter (MAX_WAIT = 8).
module tb_dram_arbiter;
  import hxd_arb_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_req, cpu_we, cpu_gnt, cpu_rvld;
  logic [31:0]     cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]      cpu_be;
  logic            host_req, host_lock, host_we, host_gnt, host_rvld;
  logic [31:0]     host_addr, host_wdata, host_rdata;
  logic [3:0]      host_be;
  logic            ram_en, ram_we;
  logic [31:0]     ram_addr, ram_wdata, ram_rdata;
  logic [3:0]      ram_be;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dram_arbiter #(.MAX_WAIT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_be_i(cpu_be), .cpu_gnt_o(cpu_gnt),
    .cpu_rvld_o(cpu_rvld), .cpu_rdata_o(cpu_rdata),
    .host_req_i(host_req), .host_lock_i(host_lock), .host_we_i(host_we),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata), .host_be_i(host_be),
    .host_gnt_o(host_gnt), .host_rvld_o(host_rvld), .host_rdata_o(host_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_be_o(ram_be), .ram_rdata_i(ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic next_slot();
    @(negedge clk);
  endtask

  initial begin
    logic exp_h, prev_h, prev_c;
    logic [31:0] d;

    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44; cpu_wdata = 32'h0; cpu_be = 4'hF;
    host_req = 1'b0; host_lock = 1'b0; host_we = 1'b0; host_addr = 32'h0;
    host_wdata = 32'h0; host_be = 4'h0; ram_rdata = 32'h0;

    // Reset with CPU requesting: nothing granted, outputs quiet.
    next_slot(); next_slot(); #1;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_host_gnt", 32'(host_gnt), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_cpu_rvld", 32'(cpu_rvld), 32'd0);

    // First cycle out of reset: CPU granted.
    next_slot(); rst = 1'b0; #1;
    chk("post_rst_cpu_gnt", 32'(cpu_gnt), 32'd1);

    // CPU read 0x10, RAM returns DEADBEEF next cycle.
    next_slot(); cpu_addr = 32'h10; cpu_be = 4'hF; ram_rdata = 32'h0; #1;
    chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_ram_addr", ram_addr, 32'h10);
    chk("rd_ram_we", 32'(ram_we), 32'd0);
    chk("rd_ram_be", 32'(ram_be), 32'd0);
    next_slot(); cpu_req = 1'b0; ram_rdata = 32'hDEADBEEF; #1;
    chk("rd_cpu_rvld", 32'(cpu_rvld), 32'd1);
    chk("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("rd_host_rvld", 32'(host_rvld), 32'd0);
    next_slot(); ram_rdata = 32'h12345678; #1;
    chk("rd_cpu_rvld_off", 32'(cpu_rvld), 32'd0);
    chk("rd_cpu_rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // Both requesting reads: 7 CPU grants then 1 HOST grant, repeating.
    prev_h = 1'b0; prev_c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      next_slot();
      cpu_req = 1'b1; cpu_addr = 32'h100; host_req = 1'b1; host_addr = 32'h200;
      d = 32'hA000_0000 + 32'(i);
      ram_rdata = d;
      #1;
      exp_h = ((i % 8) == 7);
      chk($sformatf("starve_host_gnt_%0d", i), 32'(host_gnt), 32'(exp_h));
      chk($sformatf("starve_cpu_gnt_%0d", i), 32'(cpu_gnt), 32'(!exp_h));
      chk($sformatf("starve_addr_%0d", i), ram_addr, exp_h ? 32'h200 : 32'h100);
      chk($sformatf("starve_host_rvld_%0d", i), 32'(host_rvld), 32'(prev_h));
      chk($sformatf("starve_cpu_rvld_%0d", i), 32'(cpu_rvld), 32'(prev_c));
      if (prev_h) chk($sformatf("starve_host_rdata_%0d", i), host_rdata, d);
      if (prev_c) chk($sformatf("starve_cpu_rdata_%0d", i), cpu_rdata, d);
      prev_h = exp_h; prev_c = !exp_h;
    end
    next_slot(); cpu_req = 1'b0; host_req = 1'b0; ram_rdata = 32'h5555_AAAA; #1;
    chk("starve_tail_host_rvld", 32'(host_rvld), 32'd1);
    chk("starve_tail_host_rdata", host_rdata, 32'h5555_AAAA);
    chk("starve_tail_cpu_rvld", 32'(cpu_rvld), 32'd0);

    // HOST lock: 4 HOST reads while CPU stalls, CPU wins right after lock drops.
    next_slot(); host_req = 1'b1; host_lock = 1'b1; host_addr = 32'h300; #1;
    chk("lock1_host_gnt", 32'(host_gnt), 32'd1);
    chk("lock1_cpu_gnt", 32'(cpu_gnt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      next_slot(); cpu_req = 1'b1; cpu_addr = 32'h500; #1;
      chk($sformatf("lock%0d_host_gnt", i + 2), 32'(host_gnt), 32'd1);
      chk($sformatf("lock%0d_cpu_gnt", i + 2), 32'(cpu_gnt), 32'd0);
      chk($sformatf("lock%0d_host_rvld", i + 2), 32'(host_rvld), 32'd1);
    end
    next_slot(); host_lock = 1'b0; #1;
    chk("lock4_host_gnt", 32'(host_gnt), 32'd1);
    chk("lock4_cpu_gnt", 32'(cpu_gnt), 32'd0);
    next_slot(); host_req = 1'b0; #1;
    chk("unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("unlock_host_gnt", 32'(host_gnt), 32'd0);
    chk("unlock_ram_addr", ram_addr, 32'h500);

    // HOST partial write: byte enables pass, no read response.
    next_slot(); cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b1; host_be = 4'b0010;
    host_addr = 32'h400; host_wdata = 32'h00AB0000; #1;
    chk("wr_host_gnt", 32'(host_gnt), 32'd1);
    chk("wr_ram_we", 32'(ram_we), 32'd1);
    chk("wr_ram_be", 32'(ram_be), 32'b0010);
    chk("wr_ram_wdata", ram_wdata, 32'h00AB0000);
    next_slot(); host_req = 1'b0; host_we = 1'b0; #1;
    chk("wr_host_rvld", 32'(host_rvld), 32'd0);
    chk("wr_cpu_rvld", 32'(cpu_rvld), 32'd0);

    // Reset right after a granted read drops the response and clears state.
    next_slot(); cpu_req = 1'b1; cpu_addr = 32'h20; host_req = 1'b1; host_addr = 32'h30; #1;
    chk("rst6_cpu_gnt", 32'(cpu_gnt), 32'd1);
    next_slot(); rst = 1'b1; ram_rdata = 32'hCAFEF00D; #1;
    chk("rst6_cpu_rvld", 32'(cpu_rvld), 32'd0);
    chk("rst6_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst6_host_gnt", 32'(host_gnt), 32'd0);
    next_slot(); rst = 1'b0; cpu_req = 1'b0; host_req = 1'b0; #1;
    chk("rst6_cpu_rvld_after", 32'(cpu_rvld), 32'd0);
    chk("rst6_state", 32'(dut.state_q), 32'(ARB));
    chk("rst6_wait_cnt", 32'(dut.u_wait.cnt_q), 32'd0);
    next_slot(); cpu_req = 1'b1; host_req = 1'b1; #1;
    chk("rst6_cpu_first", 32'(cpu_gnt), 32'd1);
    next_slot(); cpu_req = 1'b0; host_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
